// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register index width and ABI names.
// Imported by the register file and its read-port mux.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    // ABI register indices
    localparam int unsigned ZERO = 0;
    localparam int unsigned RA   = 1;
    localparam int unsigned SP   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mux.sv
// Parameterized N:1 data mux used for each register-file read port.
// Ports: data_i (N_INPUTS packed words), sel_i (index), data_o (selected word).
module reg_file_mux
    import riscv_pkg::*;
#(
    parameter int N_INPUTS = 2**REG_ADDR_W,
    parameter int DWIDTH   = XLEN
) (
    input  logic [N_INPUTS-1:0][DWIDTH-1:0] data_i,
    input  logic [$clog2(N_INPUTS)-1:0]     sel_i,
    output logic [DWIDTH-1:0]               data_o
);

    // N_INPUTS is a power of two, so every sel_i value is in range.
    assign data_o = data_i[sel_i];

endmodule

// File: rtl/reg_file.sv
// Integer register file: 2 combinational read ports with write-first bypass,
// 1 write port, x0 hardwired to zero, saturating committed-write counter.
// Ports: clk, rst (async, active-high), we/waddr/wdata (write),
//        raddr1/raddr2 -> rdata1/rdata2 (reads), wr_count (debug).
module reg_file
    import riscv_pkg::*;
#(
    parameter int N_REGS = 2**REG_ADDR_W,
    parameter int DWIDTH = XLEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(N_REGS)-1:0] waddr,
    input  logic [DWIDTH-1:0]         wdata,
    input  logic [$clog2(N_REGS)-1:0] raddr1,
    input  logic [$clog2(N_REGS)-1:0] raddr2,
    output logic [DWIDTH-1:0]         rdata1,
    output logic [DWIDTH-1:0]         rdata2,
    output logic [15:0]               wr_count
);

    localparam int AW = $clog2(N_REGS);

    // Only x1..xN-1 have storage; x0 is a constant zero mux input.
    logic [N_REGS-1:1][DWIDTH-1:0] regs_q;
    logic [N_REGS-1:0][DWIDTH-1:0] mux_in;
    logic [15:0]                   wr_count_q;
    logic [15:0]                   wr_count_d;
    logic [DWIDTH-1:0]             mux_rd1;
    logic [DWIDTH-1:0]             mux_rd2;
    logic                          wr_en;
    logic                          byp1;
    logic                          byp2;

    // Reset also blocks the write so bypass is off while rst is high.
    assign wr_en = we && (waddr != AW'(ZERO)) && !rst;

    always_comb begin
        mux_in = '0;
        for (int i = 1; i < N_REGS; i++) begin
            mux_in[i] = regs_q[i];
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_en && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else begin
            for (int i = 1; i < N_REGS; i++) begin
                if (wr_en && (waddr == AW'(i))) begin
                    regs_q[i] <= wdata;
                end
            end
            wr_count_q <= wr_count_d;
        end
    end

    reg_file_mux #(
        .N_INPUTS (N_REGS),
        .DWIDTH   (DWIDTH)
    ) u_mux_rd1 (
        .data_i (mux_in),
        .sel_i  (raddr1),
        .data_o (mux_rd1)
    );

    reg_file_mux #(
        .N_INPUTS (N_REGS),
        .DWIDTH   (DWIDTH)
    ) u_mux_rd2 (
        .data_i (mux_in),
        .sel_i  (raddr2),
        .data_o (mux_rd2)
    );

    // Write-first: a same-cycle write to the read index wins.
    assign byp1 = wr_en && (raddr1 == waddr);
    assign byp2 = wr_en && (raddr2 == waddr);

    always_comb begin
        rdata1 = mux_rd1;
        rdata2 = mux_rd2;
        if (rst) begin
            rdata1 = '0;
            rdata2 = '0;
        end else begin
            if (byp1) rdata1 = wdata;
            if (byp2) rdata2 = wdata;
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter N_REGS, default 32: number of architectural registers; power of two, at least 2.
REQ-002 SHALL have parameter DWIDTH, default 32: register data width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port we, input, 1: write enable for the current cycle.
REQ-006 SHALL have port waddr, input, $clog2(N_REGS): write register index.
REQ-007 SHALL have port wdata, input, DWIDTH: write data.
REQ-008 SHALL have port raddr1, input, $clog2(N_REGS): read port 1 index (rs1).
REQ-009 SHALL have port raddr2, input, $clog2(N_REGS): read port 2 index (rs2).
REQ-010 SHALL have port rdata1, output, DWIDTH: read port 1 data, combinational from raddr1.
REQ-011 SHALL have port rdata2, output, DWIDTH: read port 2 data, combinational from raddr2.
REQ-012 SHALL have port wr_count, output, 16: saturating count of committed writes (debug).

Function
REQ-013 SHALL use one clock (clk) and an asynchronous, active-high reset (rst).
REQ-014 SHALL write wdata into register waddr on the rising clk edge when we=1 and waddr!=0.
REQ-015 SHALL ignore any write to index 0; register 0 SHALL always read as 0.
REQ-016 SHALL leave all registers unchanged when we=0.
REQ-017 SHALL drive rdataN from register raddrN with zero-cycle latency (combinational read).
REQ-018 SHALL bypass: when we=1, waddr!=0 and raddrN==waddr in the same cycle, rdataN SHALL equal wdata (write-first).
REQ-019 SHALL not bypass when waddr==0; a read of 0 returns 0 even if we=1 and wdata!=0.
REQ-020 SHALL serve raddr1==raddr2 with identical data on both ports, bypass included.
REQ-021 SHALL increment wr_count by 1 per cycle with we=1 and waddr!=0, saturating at 16'hFFFF without wrap.
REQ-022 SHALL never drive X on rdata1/rdata2 for any in-range address after reset.

Reset
REQ-023 SHALL clear all registers and wr_count to 0 immediately on rst assertion, independent of clk.
REQ-024 SHALL hold state at 0 while rst=1; a write presented during reset SHALL be discarded.
REQ-025 SHALL present rdata1=rdata2=0 during reset for any address; bypass is disabled while rst=1.
REQ-026 SHALL accept the first write on the first rising clk edge after rst deasserts.

Structure
REQ-027 SHALL take REG_ADDR_W and the ABI register index constants (ZERO, RA, SP) from the shared package riscv_pkg.
REQ-028 SHALL implement each read port as one instance of the existing parameterized mux (N_INPUTS=N_REGS, DWIDTH=DWIDTH), followed by bypass logic.
REQ-029 SHALL store registers 1..N_REGS-1 in flops; no register 0 storage.

Verification
REQ-030 Reset: assert rst mid-run after writing x5=0xDEADBEEF -> rdata1(raddr1=5)=0 immediately, wr_count=0.
REQ-031 Write/read: we=1, waddr=3, wdata=0x12345678; next cycle raddr1=3 -> rdata1=0x12345678, wr_count=1.
REQ-032 x0: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1(raddr1=0)=0 same and next cycle, wr_count unchanged.
REQ-033 Bypass: x7=0x1 stored; we=1, waddr=7, wdata=0x2, raddr1=raddr2=7 -> both rdata=0x2 in the same cycle.
REQ-034 No-write: we=0, waddr=9, wdata=0xAAAA -> x9 keeps prior value 0x5555.
REQ-035 Saturation: 65540 consecutive writes to x1 -> wr_count=0xFFFF, not wrapping.
